// File: rtl/fx2_out_ep_cmd_reader.sv
// Drains FX2 OUT endpoint EP4 and parses it into writes to an 8x8 register bank.
// Define FX2_CMD_CHECKSUM_EN for 3-byte packets carrying an XOR check byte.
module fx2_out_ep_cmd_reader #(
    parameter logic [1:0] EP_ADDR    = 2'b01,
    parameter logic [7:0] REG0_RESET = 8'h01
) (
    input  logic       FX2_IFCLK,
    input  logic       MAX2_nRESET,
    input  logic       MAX2_FIFO_DIR,
    input  logic       FX2_FLAGC,
    input  logic [7:0] FX2_FD_IN,
    output logic       FX2_SLOE,
    output logic       FX2_SLRD,
    output logic [1:0] FX2_FIFOADDR,
    output logic       FX2_BUS_OWN,
    output logic       REG_WR_STROBE,
    output logic [2:0] REG_WR_ADDR,
    output logic [7:0] REG_WR_DATA,
    input  logic [2:0] REG_RD_ADDR,
    output logic [7:0] REG_RD_DATA,
    output logic       EXT_SOUND_ENABLE,
    output logic [7:0] ERR_COUNT
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CHECK,
        STROBE,
        WAIT
    } state_t;

    state_t     state;
    logic [7:0] byte_q;
    logic [1:0] byte_cnt;
    logic [7:0] regs [8];

`ifdef FX2_CMD_CHECKSUM_EN
    logic [7:0] hdr_q;
    logic [7:0] data_q;
    logic [7:0] err_q;

    assign ERR_COUNT = err_q;
`else
    logic [2:0] hdr_q;

    assign ERR_COUNT = 8'h00;
`endif

    assign FX2_FIFOADDR     = EP_ADDR;
    assign REG_RD_DATA      = regs[REG_RD_ADDR];
    assign EXT_SOUND_ENABLE = regs[0][0];

    always_ff @(posedge FX2_IFCLK or negedge MAX2_nRESET) begin
        if (!MAX2_nRESET) begin
            state         <= IDLE;
            byte_q        <= '0;
            byte_cnt      <= '0;
            hdr_q         <= '0;
`ifdef FX2_CMD_CHECKSUM_EN
            data_q        <= '0;
            err_q         <= '0;
`endif
            FX2_SLOE      <= 1'b1;
            FX2_SLRD      <= 1'b1;
            FX2_BUS_OWN   <= 1'b0;
            REG_WR_STROBE <= 1'b0;
            REG_WR_ADDR   <= '0;
            REG_WR_DATA   <= '0;
            regs[0]       <= REG0_RESET;
            for (int i = 1; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            REG_WR_STROBE <= 1'b0;
            // Losing direction abandons any partial packet; the host resyncs.
            if (state != IDLE && !MAX2_FIFO_DIR) begin
                state       <= IDLE;
                byte_cnt    <= '0;
                FX2_SLOE    <= 1'b1;
                FX2_SLRD    <= 1'b1;
                FX2_BUS_OWN <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (MAX2_FIFO_DIR) begin
                            state       <= SETUP;
                            FX2_SLOE    <= 1'b0;
                            FX2_BUS_OWN <= 1'b1;
                        end
                    end
                    SETUP: begin
                        state <= CHECK;
                    end
                    CHECK: begin
                        if (FX2_FLAGC) begin
                            byte_q   <= FX2_FD_IN;
                            FX2_SLRD <= 1'b0;
                            state    <= STROBE;
                        end
                    end
                    STROBE: begin
                        FX2_SLRD <= 1'b1;
                        state    <= WAIT;
                        unique case (byte_cnt)
                            2'd0: begin
                                if (byte_q[7]) begin
`ifdef FX2_CMD_CHECKSUM_EN
                                    hdr_q <= byte_q;
`else
                                    hdr_q <= byte_q[2:0];
`endif
                                    byte_cnt <= 2'd1;
                                end
                            end
`ifdef FX2_CMD_CHECKSUM_EN
                            2'd1: begin
                                data_q   <= byte_q;
                                byte_cnt <= 2'd2;
                            end
                            default: begin
                                byte_cnt <= 2'd0;
                                if (byte_q == (hdr_q ^ data_q ^ 8'hA5)) begin
                                    regs[hdr_q[2:0]] <= data_q;
                                    REG_WR_ADDR      <= hdr_q[2:0];
                                    REG_WR_DATA      <= data_q;
                                    REG_WR_STROBE    <= 1'b1;
                                end else if (err_q != 8'hFF) begin
                                    err_q <= err_q + 8'd1;
                                end
                            end
`else
                            default: begin
                                byte_cnt      <= 2'd0;
                                regs[hdr_q]   <= byte_q;
                                REG_WR_ADDR   <= hdr_q;
                                REG_WR_DATA   <= byte_q;
                                REG_WR_STROBE <= 1'b1;
                            end
`endif
                        endcase
                    end
                    WAIT: begin
                        state <= CHECK;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fx2_out_ep_cmd_reader.sv
// Scoreboard bench for fx2_out_ep_cmd_reader with an FX2 FIFO model.
// Build with FX2_CMD_CHECKSUM_EN defined to exercise the check-byte variant.
module tb_fx2_out_ep_cmd_reader;

`ifdef FX2_CMD_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam int PKT_LEN = CS ? 3 : 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dir;
    logic       flagc;
    logic [7:0] fd;
    logic       sloe;
    logic       slrd;
    logic [1:0] fifoaddr;
    logic       bus_own;
    logic       wr_stb;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       ext;
    logic [7:0] err;

    fx2_out_ep_cmd_reader dut (
        .FX2_IFCLK       (clk),
        .MAX2_nRESET     (rst_n),
        .MAX2_FIFO_DIR   (dir),
        .FX2_FLAGC       (flagc),
        .FX2_FD_IN       (fd),
        .FX2_SLOE        (sloe),
        .FX2_SLRD        (slrd),
        .FX2_FIFOADDR    (fifoaddr),
        .FX2_BUS_OWN     (bus_own),
        .REG_WR_STROBE   (wr_stb),
        .REG_WR_ADDR     (wr_addr),
        .REG_WR_DATA     (wr_data),
        .REG_RD_ADDR     (rd_addr),
        .REG_RD_DATA     (rd_data),
        .EXT_SOUND_ENABLE(ext),
        .ERR_COUNT       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit         is_err;
        logic [2:0] a;
        logic [7:0] d;
    } ev_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] fifo [$];
    logic [7:0] pkt [$];
    ev_t        expq [$];
    ev_t        mon_e;
    logic [7:0] mregs [8];
    int         m_err = 0;
    logic [7:0] prev_err = 8'h00;
    logic       prev_slrd = 1'b1;
    logic       flag_prev = 1'b0;
    bit         pop_pend = 1'b0;
    int         cycle = 0;
    int         last_slrd = -100;
    int         slrd_log [$];
    int         rd_fix = -1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cycle);
        end
    endtask

    // Reference parser: consumes whole packets, ignoring pads between them.
    task automatic model_byte(input logic [7:0] b);
        if (pkt.size() == 0 && !b[7]) return;
        pkt.push_back(b);
        if (pkt.size() == PKT_LEN) begin
            if (!CS || pkt[PKT_LEN-1] == (pkt[0] ^ pkt[1] ^ 8'hA5)) begin
                expq.push_back('{1'b0, pkt[0][2:0], pkt[1]});
            end else if (m_err < 255) begin
                m_err++;
                expq.push_back('{1'b1, 3'd0, 8'(m_err)});
            end
            pkt.delete();
        end
    endtask

    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] d,
                            input bit good);
        logic [7:0] c;
        send(h);
        send(d);
        if (CS) begin
            c = h ^ d ^ 8'hA5;
            if (!good) c = c ^ 8'h5C;
            send(c);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        expq.delete();
        pkt.delete();
        m_err     = 0;
        prev_err  = 8'h00;
        prev_slrd = 1'b1;
        mregs[0]  = 8'h01;
        for (int i = 1; i < 8; i++) mregs[i] = 8'h00;
    endtask

    task automatic drain();
        int t = 0;
        while (fifo.size() > 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk("drain_done", 32'(t < 4000), 1);
        chk("pending_events", expq.size(), 0);
        chk("err_count", err, m_err);
    endtask

    task automatic chk_reg(input int a, input logic [7:0] e);
        rd_fix = a;
        @(posedge clk);
        @(negedge clk);
        chk("reg_read", rd_data, e);
        rd_fix = -1;
        @(posedge clk);
        #1;
    endtask

    // FIFO model: advances on a rising edge seen with SLRD low.
    always @(negedge clk) pop_pend = rst_n && (slrd === 1'b0);

    always @(posedge clk) begin
        flag_prev = flagc;
        #1;
        if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
        pop_pend = 1'b0;
        flagc    = fifo.size() > 0;
        fd       = (fifo.size() > 0) ? fifo[0] : 8'hEE;
        rd_addr  = (rd_fix >= 0) ? 3'(rd_fix) : 3'($urandom_range(0, 7));
        cycle++;
    end

    // Monitor: pops the scoreboard on every write strobe or error bump.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (slrd === 1'b0) begin
                chk("slrd_flag", 32'(flag_prev), 1);
                chk("slrd_width", 32'(prev_slrd), 1);
                chk("slrd_gap", 32'(cycle - last_slrd >= 3), 1);
                last_slrd = cycle;
                slrd_log.push_back(cycle);
            end
            prev_slrd = slrd;
            if (wr_stb === 1'b1) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL strobe_unexpected: got addr %0d data %02h, expected none",
                             wr_addr, wr_data);
                end else begin
                    mon_e = expq.pop_front();
                    chk("stb_kind", 32'(mon_e.is_err), 0);
                    chk("stb_addr", wr_addr, mon_e.a);
                    chk("stb_data", wr_data, mon_e.d);
                    chk("stb_latency", cycle - last_slrd, 1);
                    if (!mon_e.is_err) mregs[mon_e.a] = mon_e.d;
                end
            end
            if (err !== prev_err) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL err_unexpected: got %0d, expected %0d", err, prev_err);
                end else begin
                    mon_e = expq.pop_front();
                    chk("err_kind", 32'(mon_e.is_err), 1);
                    chk("err_step", err, mon_e.d);
                    chk("err_latency", cycle - last_slrd, 1);
                end
                prev_err = err;
            end
            chk("ext_sound", 32'(ext), 32'(mregs[0][0]));
            chk("rd_data", rd_data, mregs[rd_addr]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish within limit");
        $fatal(1);
    end

    initial begin
        int n0;
        int w;
        rst_n   = 1'b0;
        dir     = 1'b0;
        flagc   = 1'b0;
        fd      = 8'hEE;
        rd_addr = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sloe", sloe, 1);
        chk("rst_slrd", slrd, 1);
        chk("rst_bus_own", bus_own, 0);
        chk("rst_strobe", wr_stb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_err", err, 0);
        chk("rst_ext", ext, 1);
        chk("fifoaddr", fifoaddr, 2'b01);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("idle_sloe", sloe, 1);
        chk("idle_bus_own", bus_own, 0);
        chk("idle_no_reads", slrd_log.size(), 0);
        chk_reg(0, 8'h01);

        // Direction rise: SLOE drops after one edge.
        dir = 1'b1;
        @(negedge clk);
        chk("dir_idle_sloe", sloe, 1);
        @(negedge clk);
        chk("dir_setup_sloe", sloe, 0);
        chk("dir_setup_own", bus_own, 1);
        repeat (3) @(posedge clk);
        #1;

        n0 = slrd_log.size();
        send_pkt(8'h83, 8'h5A, 1'b1);
        drain();
        chk("t2_pulses", slrd_log.size() - n0, PKT_LEN);
        for (int i = 1; i < PKT_LEN; i++)
            chk("t2_gap", slrd_log[n0+i] - slrd_log[n0+i-1], 3);
        chk_reg(3, 8'h5A);

        send(8'h00);
        send(8'h00);
        send_pkt(8'h80, 8'h00, 1'b1);
        drain();
        chk_reg(0, 8'h00);
        chk("t3_ext", ext, 0);

        // Empty FIFO between header and data.
        send(8'h84);
        drain();
        n0 = slrd_log.size();
        repeat (10) @(posedge clk);
        #1;
        chk("stall_no_reads", slrd_log.size() - n0, 0);
        send(8'h3C);
        if (CS) send(8'h84 ^ 8'h3C ^ 8'hA5);
        drain();
        chk_reg(4, 8'h3C);

        // Direction drop after a header.
        send(8'h85);
        drain();
        chk("pre_drop_own", bus_own, 1);
        dir = 1'b0;
        pkt.delete();
        @(posedge clk);
        @(negedge clk);
        chk("drop_sloe", sloe, 1);
        chk("drop_own", bus_own, 0);
        chk("drop_slrd", slrd, 1);
        chk("drop_strobe", wr_stb, 0);
        repeat (3) @(posedge clk);
        #1;
        dir = 1'b1;
        send_pkt(8'h81, 8'h22, 1'b1);
        drain();
        chk_reg(1, 8'h22);

`ifdef FX2_CMD_CHECKSUM_EN
        send(8'h82);
        send(8'h11);
        send(8'h00);
        drain();
        chk("bad_check_err", err, 1);
        for (int i = 0; i < 300; i++) send_pkt(8'h82, 8'($urandom), 1'b0);
        drain();
        chk("err_saturate", err, 8'hFF);
`endif

        for (int p = 0; p < 150; p++) begin
            w = $urandom_range(0, 2);
            for (int k = 0; k < w; k++) send(8'($urandom_range(0, 127)));
            send_pkt({1'b1, 4'($urandom), 3'($urandom)}, 8'($urandom),
                     $urandom_range(0, 4) != 0);
            w = $urandom_range(0, 3);
            if (w > 0) begin
                repeat (w) @(posedge clk);
                #1;
            end
        end
        drain();
        for (int a = 0; a < 8; a++) chk_reg(a, mregs[a]);

        // Asynchronous reset in the middle of a packet.
        send_pkt(8'h86, 8'h99, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_sloe", sloe, 1);
        chk("arst_slrd", slrd, 1);
        chk("arst_own", bus_own, 0);
        chk("arst_strobe", wr_stb, 0);
        chk("arst_err", err, 0);
        chk("arst_ext", ext, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_pkt(8'h87, 8'hC3, 1'b1);
        drain();
        chk_reg(7, 8'hC3);
        chk_reg(6, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
